// File: rtl/wrap_event_reporter.sv
// wrap_event_reporter: watches a free-running down counter, counts its wraps
// (0 -> all-ones) into a modular epoch, and queues each new epoch in a small
// FIFO offered over a valid/ready handshake. Dropped events set a sticky
// overflow flag.
// Optional build macro ERR_CHECK_EN adds a sticky seq_err flag for count
// discontinuities. Without the macro, seq_err is tied to 0.
module wrap_event_reporter #(
    parameter int CNT_W   = 4,
    parameter int EPOCH_W = 8,
    parameter int DEPTH   = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [CNT_W-1:0]         cnt_in,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [EPOCH_W-1:0]       out_epoch,
    output logic [$clog2(DEPTH):0]   out_level,
    output logic                     overflow,
    output logic                     seq_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] FULL = LW'(DEPTH);

    logic [CNT_W-1:0]               prev_q, prev_d;
    logic                           prev_valid_q;
    logic [EPOCH_W-1:0]             epoch_q, epoch_d, epoch_inc;
    logic [DEPTH-1:0][EPOCH_W-1:0]  mem_q;
    logic [AW-1:0]                  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]                  level_q, level_d;
    logic                           overflow_q, overflow_d;

    logic wrap, full, pop, push, drop;

    // The wrap is seen as the transition from a sampled 0 to all-ones.
    // The first cycle after reset has no valid history, so it is ignored.
    assign wrap      = prev_valid_q && (prev_q == '0) && (cnt_in == {CNT_W{1'b1}});
    assign epoch_inc = epoch_q + EPOCH_W'(1);
    assign full      = (level_q == FULL);
    // Pop decisions use the registered level only, so a just-pushed entry
    // is never forwarded in the same cycle.
    assign pop       = (level_q != '0) && out_ready;
    // A full FIFO can still accept an entry when the head leaves in the same cycle.
    assign push      = wrap && (!full || pop);
    assign drop      = wrap && full && !pop;

    assign out_valid = (level_q != '0);
    assign out_epoch = out_valid ? mem_q[rd_ptr_q] : '0;
    assign out_level = level_q;
    assign overflow  = overflow_q;

    // Next-state for the sampler, epoch counter, FIFO pointers and flags.
    always_comb begin
        prev_d     = cnt_in;
        epoch_d    = epoch_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        overflow_d = overflow_q;
        // The epoch advances on every wrap, whether or not the push is dropped.
        if (wrap)
            epoch_d = epoch_inc;
        if (push)
            wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop)
            rd_ptr_d = rd_ptr_q + AW'(1);
        if (push && !pop)
            level_d = level_q + LW'(1);
        else if (!push && pop)
            level_d = level_q - LW'(1);
        if (drop)
            overflow_d = 1'b1;
    end

    // State registers. An asynchronous reset clears everything, including
    // queued epochs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_q       <= '0;
            prev_valid_q <= 1'b0;
            epoch_q      <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            level_q      <= '0;
            overflow_q   <= 1'b0;
        end else begin
            prev_q       <= prev_d;
            prev_valid_q <= 1'b1;
            epoch_q      <= epoch_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            level_q      <= level_d;
            overflow_q   <= overflow_d;
        end
    end

    // FIFO storage. The pushed value is the post-increment epoch, so the
    // first wrap pushes 1.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            mem_q <= '0;
        else if (push)
            mem_q[wr_ptr_q] <= epoch_inc;
    end

`ifdef ERR_CHECK_EN
    logic [CNT_W-1:0] prev_dec;
    logic             seq_err_q, seq_err_d;

    assign prev_dec = prev_q - CNT_W'(1);

    // Any step other than a decrement by one is a discontinuity.
    // Wrap detection runs independently of this check.
    always_comb begin
        seq_err_d = seq_err_q;
        if (prev_valid_q && (cnt_in != prev_dec))
            seq_err_d = 1'b1;
    end

    // Sticky discontinuity flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            seq_err_q <= 1'b0;
        else
            seq_err_q <= seq_err_d;
    end

    assign seq_err = seq_err_q;
`else
    assign seq_err = 1'b0;
`endif

endmodule

// File: tb/tb_wrap_event_reporter.sv
// Directed testbench for wrap_event_reporter. The bench acts as the 4-bit
// down counter feeding cnt_in. A second instance with EPOCH_W=2 shares the
// inputs and is used to check epoch wraparound.
module tb_wrap_event_reporter;

    logic       clk;
    logic       reset;
    logic [3:0] cnt_in;
    logic       out_ready;
    logic       out_valid, overflow, seq_err;
    logic [7:0] out_epoch;
    logic [2:0] out_level;
    logic       out_valid2, overflow2, seq_err2;
    logic [1:0] out_epoch2;
    logic [2:0] out_level2;

    int  passed;
    int  total;
    int  ecnt;
    bit  run;

`ifdef ERR_CHECK_EN
    localparam int EXP_SEQ = 1;
`else
    localparam int EXP_SEQ = 0;
`endif

    wrap_event_reporter dut (
        .clk(clk), .reset(reset), .cnt_in(cnt_in),
        .out_valid(out_valid), .out_ready(out_ready), .out_epoch(out_epoch),
        .out_level(out_level), .overflow(overflow), .seq_err(seq_err)
    );

    wrap_event_reporter #(.EPOCH_W(2)) dut2 (
        .clk(clk), .reset(reset), .cnt_in(cnt_in),
        .out_valid(out_valid2), .out_ready(out_ready), .out_epoch(out_epoch2),
        .out_level(out_level2), .overflow(overflow2), .seq_err(seq_err2)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    // One clock edge. Outputs are sampled 1ns later, and then the counter
    // model steps down.
    task automatic tick();
        @(posedge clk);
        #1;
        ecnt++;
        if (run) cnt_in = cnt_in - 4'd1;
    endtask

    // From reset release with the counter at 0, the wraps land on edges 2, 18, 34, ...
    task automatic to_wrap();
        do tick(); while (ecnt % 16 != 2);
    endtask

    task automatic do_reset(input logic [3:0] v);
        reset  = 1'b1;
        cnt_in = v;
        ecnt   = 0;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        clk = 1'b0; reset = 1'b1; cnt_in = 4'd0; out_ready = 1'b1;
        ecnt = 0; passed = 0; total = 0; run = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_valid",    32'(out_valid), 0);
        chk("rst_epoch",    32'(out_epoch), 0);
        chk("rst_level",    32'(out_level), 0);
        chk("rst_overflow", 32'(overflow),  0);
        chk("rst_seq_err",  32'(seq_err),   0);
        reset = 1'b0;

        // Reset release with the counter at 0. Epoch 1 appears after the 2nd edge.
        tick();
        chk("t1_e1_valid", 32'(out_valid), 0);
        tick();
        chk("t1_valid",    32'(out_valid),  1);
        chk("t1_epoch",    32'(out_epoch),  1);
        chk("t1_level",    32'(out_level),  1);
        chk("t1_overflow", 32'(overflow),   0);
        chk("t1_epoch_w2", 32'(out_epoch2), 1);

        // Ready held high: each epoch is valid for exactly one cycle, 16 cycles apart.
        tick();
        chk("t2_pop1", 32'(out_valid), 0);
        for (int e = 2; e <= 4; e++) begin
            repeat (14) tick();
            chk("t2_pre",      32'(out_valid),  0);
            tick();
            chk("t2_valid",    32'(out_valid),  1);
            chk("t2_epoch",    32'(out_epoch),  32'(e));
            chk("t2_epoch_w2", 32'(out_epoch2), 32'(e % 4));
            tick();
            chk("t2_popped",   32'(out_valid),  0);
        end
        chk("t2_seq_err", 32'(seq_err), 0);

        // Ready low through 5 wraps: the FIFO fills and the 5th wrap is dropped.
        do_reset(4'd0);
        out_ready = 1'b0;
        repeat (4) to_wrap();
        chk("t3_full_level", 32'(out_level), 4);
        chk("t3_full_ovf",   32'(overflow),  0);
        to_wrap();
        chk("t3_level",    32'(out_level), 4);
        chk("t3_overflow", 32'(overflow),  1);
        chk("t3_head",     32'(out_epoch), 1);
        out_ready = 1'b1;
        for (int e = 2; e <= 4; e++) begin
            tick();
            chk("t3_drain", 32'(out_epoch), 32'(e));
        end
        tick();
        chk("t3_empty_valid", 32'(out_valid), 0);
        chk("t3_empty_level", 32'(out_level), 0);
        to_wrap();
        chk("t3_next_epoch", 32'(out_epoch), 6);
        chk("t3_sticky_ovf", 32'(overflow),  1);

        // Full FIFO with a pop in the wrap cycle: head 1 leaves and 5 enters.
        do_reset(4'd0);
        out_ready = 1'b0;
        repeat (4) to_wrap();
        repeat (15) tick();
        out_ready = 1'b1;
        tick();
        chk("t4_level",    32'(out_level), 4);
        chk("t4_overflow", 32'(overflow),  0);
        chk("t4_head",     32'(out_epoch), 2);
        for (int e = 3; e <= 5; e++) begin
            tick();
            chk("t4_drain", 32'(out_epoch), 32'(e));
        end
        tick();
        chk("t4_empty", 32'(out_level), 0);

        // Mid-operation reset with 3 entries queued.
        do_reset(4'd0);
        out_ready = 1'b0;
        repeat (3) to_wrap();
        chk("t6_queued", 32'(out_level), 3);
        reset = 1'b1;
        #2;
        chk("t6_valid",    32'(out_valid), 0);
        chk("t6_level",    32'(out_level), 0);
        chk("t6_epoch",    32'(out_epoch), 0);
        chk("t6_overflow", 32'(overflow),  0);
        do_reset(4'd0);
        out_ready = 1'b1;
        to_wrap();
        chk("t6_restart",    32'(out_epoch),  1);
        chk("t6_restart_w2", 32'(out_epoch2), 1);
        chk("t6_seq_err",    32'(seq_err),    0);

        // Discontinuity: 8, 7 (clean), then 5 (skip).
        run = 1'b0;
        do_reset(4'd8);
        tick();
        cnt_in = 4'd7;
        tick();
        chk("t5_clean", 32'(seq_err), 0);
        cnt_in = 4'd5;
        tick();
        chk("t5_err", 32'(seq_err), 32'(EXP_SEQ));
        cnt_in = 4'd4;
        tick();
        chk("t5_sticky", 32'(seq_err),  32'(EXP_SEQ));
        chk("t5_ovf",    32'(overflow), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
